// File: rtl/i3c_bus_cond_gen.sv
// ---------------------------------------------------------------------------
// i3c_bus_cond_gen
//
// Bus-condition generator for an I3C/I2C master. It sits between the master
// control register and the pad ring. It converts START/STOP trigger bits in
// the control word into timed START, Repeated-START and STOP sequences on
// the open-drain SCL/SDA pins. While the bus is ACTIVE, SCL and SDA are held
// low and the byte engine owns the bus.
//
// Ports
//   i_clk         clock; all logic runs on the rising edge
//   i_rst         asynchronous, active-high reset
//   i_ctrl_reg    control word: [0] START, [1] STOP, [3] EN, [31] SOFT_RST
//   i_scl_in      sampled SCL pad level, used to detect clock stretching
//   o_scl_oe      1 = pull SCL low, 0 = release
//   o_sda_oe      1 = pull SDA low, 0 = release
//   o_busy        1 in every state except IDLE and ACTIVE
//   o_bus_active  1 in ACTIVE (START done, SCL held low)
//   o_start_done  1-cycle pulse when a (Repeated) START completes
//   o_stop_done   1-cycle pulse when STOP plus the bus-free time completes
//   o_req_err     1-cycle pulse when a request is dropped
//   o_dbg_state   current FSM state, for debug and checker binding
//
// Handshake: there is none. A request is a rising edge of a control bit,
// taken only while EN=1. A request is never queued: it is accepted in IDLE
// or ACTIVE, and is otherwise dropped with an o_req_err pulse.
// ---------------------------------------------------------------------------
module i3c_bus_cond_gen #(
    parameter int T_SU  = 4,
    parameter int T_HD  = 4,
    parameter int T_BUF = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_ctrl_reg,
    input  logic        i_scl_in,
    output logic        o_scl_oe,
    output logic        o_sda_oe,
    output logic        o_busy,
    output logic        o_bus_active,
    output logic        o_start_done,
    output logic        o_stop_done,
    output logic        o_req_err,
    output logic [3:0]  o_dbg_state
);

    localparam int T_MAX_A = (T_SU > T_HD) ? T_SU : T_HD;
    localparam int T_MAX   = (T_MAX_A > T_BUF) ? T_MAX_A : T_BUF;
    localparam int CW      = $clog2(T_MAX + 1);

    typedef enum logic [3:0] {
        S_IDLE         = 4'd0,
        S_START_SU     = 4'd1,
        S_START_HD     = 4'd2,
        S_START_LOW    = 4'd3,
        S_ACTIVE       = 4'd4,
        S_RS_SDA       = 4'd5,
        S_RS_SCL       = 4'd6,
        S_STOP_SDA     = 4'd7,
        S_STOP_SCL     = 4'd8,
        S_STOP_SDA_REL = 4'd9,
        S_BUF          = 4'd10
    } state_t;

    // Control word fields.
    logic       ctrl_start;
    logic       ctrl_stop;
    logic       ctrl_en;
    logic       ctrl_soft_rst;
    logic       unused_ctrl;

    assign ctrl_start    = i_ctrl_reg[0];
    assign ctrl_stop     = i_ctrl_reg[1];
    assign ctrl_en       = i_ctrl_reg[3];
    assign ctrl_soft_rst = i_ctrl_reg[31];
    assign unused_ctrl   = ^{i_ctrl_reg[30:4], i_ctrl_reg[2]};

    // State, counter and edge registers.
    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      ctrl_d1_q;
    logic [1:0]      edge_q, edge_d;

    // Registered outputs.
    logic            scl_oe_q, sda_oe_q, busy_q, active_q;
    logic            start_done_q, stop_done_q, req_err_q;
    logic            start_done_d, stop_done_d, req_err_d;

    logic            start_req, stop_req;
    logic            cnt_tick, cnt_last;

    // Pin levels for each state. Keeping them together makes the waveform
    // easy to compare against the bus-condition diagrams.
    function automatic logic scl_oe_of(input state_t s);
        return (s == S_START_LOW) || (s == S_ACTIVE) ||
               (s == S_RS_SDA)    || (s == S_STOP_SDA);
    endfunction

    function automatic logic sda_oe_of(input state_t s);
        return (s == S_START_HD) || (s == S_START_LOW) || (s == S_ACTIVE) ||
               (s == S_STOP_SDA) || (s == S_STOP_SCL);
    endfunction

    function automatic logic busy_of(input state_t s);
        return (s != S_IDLE) && (s != S_ACTIVE);
    endfunction

    // Length loaded into the counter when a timed state is entered.
    // A value of 0 means the state has no counted duration.
    function automatic logic [CW-1:0] load_of(input state_t s);
        case (s)
            S_START_SU, S_RS_SDA, S_RS_SCL,
            S_STOP_SDA, S_STOP_SCL:          return CW'(T_SU);
            S_START_HD:                      return CW'(T_HD);
            S_BUF:                           return CW'(T_BUF);
            default:                         return '0;
        endcase
    endfunction

    assign start_req = edge_q[0];
    assign stop_req  = edge_q[1];

    // While SCL is released by this master, a slave may hold it low. The
    // counter then pauses, so the timing starts only once SCL is high.
    assign cnt_tick = (cnt_q != '0) && (scl_oe_of(state_q) || i_scl_in);
    assign cnt_last = cnt_tick && (cnt_q == CW'(1));

    // Rising-edge detection. A request is taken only while EN=1. Requests
    // that arrive during soft reset are discarded.
    always_comb begin
        edge_d = '0;
        if (!ctrl_soft_rst) begin
            edge_d = {ctrl_stop, ctrl_start} & ~ctrl_d1_q & {2{ctrl_en}};
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        start_done_d = 1'b0;
        stop_done_d  = 1'b0;
        req_err_d    = 1'b0;

        if (ctrl_soft_rst) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_req) begin
                        state_d   = S_START_SU;
                        // A STOP that arrives with a START loses.
                        req_err_d = stop_req;
                    end else if (stop_req) begin
                        // STOP on an idle bus has nothing to end.
                        req_err_d = 1'b1;
                    end
                end
                S_START_SU: begin
                    if (cnt_last) state_d = S_START_HD;
                end
                S_START_HD: begin
                    if (cnt_last) state_d = S_START_LOW;
                end
                S_START_LOW: begin
                    state_d = S_ACTIVE;
                end
                S_ACTIVE: begin
                    if (start_req) begin
                        state_d   = S_RS_SDA;
                        req_err_d = stop_req;
                    end else if (stop_req) begin
                        state_d = S_STOP_SDA;
                    end
                end
                S_RS_SDA: begin
                    if (cnt_last) state_d = S_RS_SCL;
                end
                S_RS_SCL: begin
                    if (cnt_last) state_d = S_START_HD;
                end
                S_STOP_SDA: begin
                    if (cnt_last) state_d = S_STOP_SCL;
                end
                S_STOP_SCL: begin
                    if (cnt_last) state_d = S_STOP_SDA_REL;
                end
                S_STOP_SDA_REL: begin
                    state_d = S_BUF;
                end
                S_BUF: begin
                    if (cnt_last) begin
                        state_d     = S_IDLE;
                        stop_done_d = 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase

            // Requests are not queued. Any edge in a busy state is dropped.
            if (busy_of(state_q) && (edge_q != 2'b00)) begin
                req_err_d = 1'b1;
            end

            // START_LOW lasts exactly one cycle, so entering it marks the end
            // of the (Repeated) START.
            start_done_d = (state_d == S_START_LOW);
        end

        // The counter is loaded on state entry and otherwise counts down.
        if (ctrl_soft_rst) begin
            cnt_d = '0;
        end else if (state_d != state_q) begin
            cnt_d = load_of(state_d);
        end else if (cnt_tick) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Single sequential block for the FSM. The pin outputs are decoded from
    // the next state, so they change in the same cycle as the state does.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            ctrl_d1_q    <= 2'b00;
            edge_q       <= 2'b00;
            scl_oe_q     <= 1'b0;
            sda_oe_q     <= 1'b0;
            busy_q       <= 1'b0;
            active_q     <= 1'b0;
            start_done_q <= 1'b0;
            stop_done_q  <= 1'b0;
            req_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ctrl_d1_q    <= {ctrl_stop, ctrl_start};
            edge_q       <= edge_d;
            scl_oe_q     <= scl_oe_of(state_d);
            sda_oe_q     <= sda_oe_of(state_d);
            busy_q       <= busy_of(state_d);
            active_q     <= (state_d == S_ACTIVE);
            start_done_q <= start_done_d;
            stop_done_q  <= stop_done_d;
            req_err_q    <= req_err_d;
        end
    end

    assign o_scl_oe     = scl_oe_q;
    assign o_sda_oe     = sda_oe_q;
    assign o_busy       = busy_q;
    assign o_bus_active = active_q;
    assign o_start_done = start_done_q;
    assign o_stop_done  = stop_done_q;
    assign o_req_err    = req_err_q;
    assign o_dbg_state  = state_q;

endmodule
